ecc_secded_channel: RTL and testbench
=====================================

# ecc_secded_channel

Parametrised, pipelined SECDED (Hamming + overall parity) transmission channel: encodes each accepted data word, optionally corrupts one or two codeword bits under test control, then decodes, corrects single-bit errors and flags double-bit errors. It sits between a data producer and consumer as a fault-injectable link model with valid/ready flow control and running error statistics. It supersedes the combinational single-word channel: the width is generic, the pipeline is registered with back-pressure, and it adds correction, double-error detection and counters.

## Interface
- DATA_W, 8: data word width, ≥ 4.
- CNT_W, 16: width of each error counter.
- Derived: P = smallest integer with 2^P ≥ DATA_W+P+1; CODE_W = DATA_W+P+1 (13 for DATA_W=8); IDX_W = clog2(CODE_W).
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept input this cycle.
- in_data  in  DATA_W  data word.
- inject_mode  in  2  00 none, 01 single-bit flip, 10 double-bit flip, 11 treated as 00; sampled with in_data.
- inject_pos  in  IDX_W  codeword bit to flip; sampled with in_data.
- out_valid  out  1  decoded word present.
- out_ready  in  1  consumer accepts this cycle.
- out_data  out  DATA_W  decoded (corrected where possible) data.
- out_corrected  out  1  single error detected and corrected.
- out_uncorrectable  out  1  double error detected (or invalid syndrome); out_data is the uncorrected received data.
- clr_cnt  in  1  synchronous clear of both counters.
- single_err_cnt  out  CNT_W  saturating count of delivered words with out_corrected=1.
- double_err_cnt  out  CNT_W  saturating count of delivered words with out_uncorrectable=1.

## Operation
- Codeword layout: bit 0 = overall parity; bits 1..CODE_W-1 are Hamming positions; parity bit k sits at position 2^k; data bits fill remaining positions in ascending order, in_data[0] at the lowest.
- Parity bit k = XOR of all positions with bit k set in their index; overall parity = XOR of bits 1..CODE_W-1 (even parity over the full codeword).
- Injection (stage 1): mode 01 flips bit inject_pos; mode 10 flips inject_pos and (inject_pos+1) mod CODE_W. inject_pos ≥ CODE_W: no flip for either mode.
- Decode (stage 2): syndrome S = XOR of indices of set bits 1..CODE_W-1; p = XOR of all CODE_W bits.
  - S=0, p=0: clean; flags 0.
  - p=1, S=0: overall parity bit in error; data unchanged; out_corrected=1.
  - p=1, 0<S<CODE_W: flip bit S, extract data; out_corrected=1.
  - p=1, S≥CODE_W: out_uncorrectable=1, raw data.
  - p=0, S≠0: out_uncorrectable=1, raw data.
- out_corrected and out_uncorrectable are never both 1.
- Counters increment only on an output handshake (out_valid & out_ready), saturate at 2^CNT_W−1; clr_cnt wins over a same-cycle increment.

## Timing
- Two register stages: S1 (encoded + injected codeword, valid bit), S2 (decoded data + flags, valid bit). Input accepted on in_valid & in_ready; out_valid rises 2 cycles later if not stalled.
- S2 loads when empty or out_ready=1; S1 loads when empty or S2 is loading. in_ready = !s1_valid | s2_load (combinational; no combinational path from in_valid).
- Full throughput 1 word/cycle with out_ready held high; with out_ready=0 the pipeline fills to 2 words, then in_ready=0; out_* held stable while out_valid & !out_ready.
- Reset (asynchronous, any time incl. mid-transfer): both valid bits, out_data, flags and counters clear to 0; in-flight words discarded; in_ready=1 once rst_n released (empty pipeline). Counters update in the cycle after the handshake.

## Test plan
- Clean stream: 0xAA, 0xCC, 0xF0, 0x01 with mode 00, out_ready=1 -> same data out in order, 2-cycle latency, flags 0, both counters 0.
- Single errors: 0xCC with mode 01 at each inject_pos 0..12 -> out_data 0xCC, out_corrected=1 each time, single_err_cnt=13.
- Double errors: 0x55 mode 10 pos 3 -> out_uncorrectable=1, out_corrected=0, double_err_cnt increments by 1; pos 12 (wraps to bit 0) -> also uncorrectable.
- Back-pressure: stream 0x10..0x14 with out_ready=0 for 5 cycles -> in_ready=0 after 2 accepts, out_data held 0x10; after release, 0x10..0x14 delivered in order, no loss/duplication.
- Counter edges: CNT_W=2, 5 single errors -> single_err_cnt saturates at 3; clr_cnt asserted in a handshake cycle -> counter reads 0.
- Reset mid-stream: assert rst_n=0 with 2 words in flight -> out_valid=0 and counters 0 immediately; after release in_ready=1 and next word 0x3C returns clean.

Source files
------------

// File: rtl/ecc_secded_channel.sv
// rtl/ecc_secded_channel.sv - pipelined SECDED encode, fault-inject and decode channel with error counters
module ecc_secded_channel #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16,
  localparam int P      = $clog2(DATA_W + 1 + $clog2(DATA_W + 1)),
  localparam int CODE_W = DATA_W + P + 1,
  localparam int IDX_W  = $clog2(CODE_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        inject_mode,
  input  logic [IDX_W-1:0]  inject_pos,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_corrected,
  output logic              out_uncorrectable,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  single_err_cnt,
  output logic [CNT_W-1:0]  double_err_cnt
);

  logic              s1_valid_q, s1_valid_d;
  logic              s2_valid_q, s2_valid_d;
  logic [CODE_W-1:0] s1_cw_q, s1_cw_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              corr_q, corr_d;
  logic              unc_q, unc_d;
  logic [CNT_W-1:0]  single_cnt_q, single_cnt_d;
  logic [CNT_W-1:0]  double_cnt_q, double_cnt_d;

  logic              s1_load, s2_load, out_hs;
  logic [CODE_W-1:0] data_spread, enc_cw, inj_mask;
  logic [IDX_W-1:0]  enc_syn, dec_syn, pos_b;
  logic              dec_par, dec_flip, dec_corr, dec_unc;
  logic [DATA_W-1:0] dec_data;

  // Data bits occupy every non-power-of-two position >= 3, in ascending order.
  for (genvar pos = 0; pos < CODE_W; pos++) begin : g_map
    if (pos != 0 && (pos & (pos - 1)) != 0) begin : g_data
      localparam int DI = pos - 1 - $clog2(pos + 1);
      assign data_spread[pos] = in_data[DI];
      assign dec_data[DI]     = s1_cw_q[pos] ^ (dec_flip && (dec_syn == IDX_W'(pos)));
    end else begin : g_check
      assign data_spread[pos] = 1'b0;
    end
  end

  always_comb begin
    enc_syn = '0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if (data_spread[pos]) enc_syn = enc_syn ^ IDX_W'(pos);
    end
    enc_cw = data_spread;
    for (int k = 0; k < P; k++) enc_cw[2**k] = enc_syn[k];
    enc_cw[0] = ^enc_cw[CODE_W-1:1];
  end

  always_comb begin
    pos_b    = (int'(inject_pos) == CODE_W - 1) ? '0 : inject_pos + 1'b1;
    inj_mask = '0;
    if (int'(inject_pos) < CODE_W) begin
      case (inject_mode)
        2'b01: inj_mask[inject_pos] = 1'b1;
        2'b10: begin
          inj_mask[inject_pos] = 1'b1;
          inj_mask[pos_b]      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Odd parity with an in-range syndrome is a single error; syndrome 0 means bit 0 itself flipped.
  always_comb begin
    dec_syn = '0;
    for (int pos = 1; pos < CODE_W; pos++) begin
      if (s1_cw_q[pos]) dec_syn = dec_syn ^ IDX_W'(pos);
    end
    dec_par  = ^s1_cw_q;
    dec_flip = 1'b0;
    dec_corr = 1'b0;
    dec_unc  = 1'b0;
    if (dec_par) begin
      dec_corr = (int'(dec_syn) < CODE_W);
      dec_unc  = !dec_corr;
      dec_flip = dec_corr && (dec_syn != '0);
    end else begin
      dec_unc = (dec_syn != '0);
    end
  end

  always_comb begin
    s2_load = !s2_valid_q || out_ready;
    s1_load = !s1_valid_q || s2_load;
    out_hs  = s2_valid_q && out_ready;

    s1_valid_d = s1_load ? in_valid : s1_valid_q;
    s1_cw_d    = (s1_load && in_valid) ? (enc_cw ^ inj_mask) : s1_cw_q;

    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
    out_data_d = out_data_q;
    corr_d     = corr_q;
    unc_d      = unc_q;
    if (s2_load && s1_valid_q) begin
      out_data_d = dec_data;
      corr_d     = dec_corr;
      unc_d      = dec_unc;
    end

    single_cnt_d = single_cnt_q;
    double_cnt_d = double_cnt_q;
    if (clr_cnt) begin
      single_cnt_d = '0;
      double_cnt_d = '0;
    end else if (out_hs) begin
      if (corr_q && single_cnt_q != '1) single_cnt_d = single_cnt_q + 1'b1;
      if (unc_q && double_cnt_q != '1) double_cnt_d = double_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s2_valid_q   <= 1'b0;
      s1_cw_q      <= '0;
      out_data_q   <= '0;
      corr_q       <= 1'b0;
      unc_q        <= 1'b0;
      single_cnt_q <= '0;
      double_cnt_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s2_valid_q   <= s2_valid_d;
      s1_cw_q      <= s1_cw_d;
      out_data_q   <= out_data_d;
      corr_q       <= corr_d;
      unc_q        <= unc_d;
      single_cnt_q <= single_cnt_d;
      double_cnt_q <= double_cnt_d;
    end
  end

  assign in_ready          = s1_load;
  assign out_valid         = s2_valid_q;
  assign out_data          = out_data_q;
  assign out_corrected     = corr_q;
  assign out_uncorrectable = unc_q;
  assign single_err_cnt    = single_cnt_q;
  assign double_err_cnt    = double_cnt_q;

endmodule

// File: tb/tb_ecc_secded_channel.sv
// tb/tb_ecc_secded_channel.sv - randomized self-checking bench for ecc_secded_channel
module tb_ecc_secded_channel;

  localparam int CODE_W = 13;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, clr_cnt;
  logic [7:0]  in_data, out_data;
  logic [1:0]  inject_mode;
  logic [3:0]  inject_pos;
  logic        out_corrected, out_uncorrectable;
  logic [15:0] single_err_cnt, double_err_cnt;
  logic        in_ready_s, out_valid_s, out_corrected_s, out_uncorrectable_s;
  logic [7:0]  out_data_s;
  logic [1:0]  single_err_cnt_s, double_err_cnt_s;

  logic [9:0]  got_q[$];
  logic [9:0]  exp_q[$];
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ecc_secded_channel #(.DATA_W(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .inject_mode(inject_mode), .inject_pos(inject_pos), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_corrected(out_corrected), .out_uncorrectable(out_uncorrectable),
    .clr_cnt(clr_cnt), .single_err_cnt(single_err_cnt), .double_err_cnt(double_err_cnt)
  );

  ecc_secded_channel #(.DATA_W(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .inject_mode(inject_mode), .inject_pos(inject_pos), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_data(out_data_s), .out_corrected(out_corrected_s), .out_uncorrectable(out_uncorrectable_s),
    .clr_cnt(clr_cnt), .single_err_cnt(single_err_cnt_s), .double_err_cnt(double_err_cnt_s)
  );

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid && out_ready)
      got_q.push_back({out_data, out_corrected, out_uncorrectable});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Flipping codeword position q changes data bit k when q is the k-th non-power-of-two position.
  function automatic logic [7:0] flip_data(input logic [7:0] d, input int q);
    int idx = 0;
    logic [7:0] r = d;
    if (q == 0 || (q & (q - 1)) == 0) return r;
    for (int j = 1; j < q; j++) if ((j & (j - 1)) != 0) idx++;
    r[idx] = ~r[idx];
    return r;
  endfunction

  function automatic logic [9:0] model(input logic [7:0] d, input logic [1:0] m, input logic [3:0] p);
    int a = int'(p);
    if (a >= CODE_W || m == 2'b00 || m == 2'b11) return {d, 2'b00};
    if (m == 2'b01) return {d, 2'b10};
    return {flip_data(flip_data(d, a), (a + 1) % CODE_W), 2'b01};
  endfunction

  task automatic send(input logic [7:0] d, input logic [1:0] m, input logic [3:0] p);
    int n = 0;
    in_data = d; inject_mode = m; inject_pos = p; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) begin
      errors++;
      $display("FAIL send_accept in_ready=%b required=1 data=%h", in_ready, d);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(model(d, m, p));
  endtask

  task automatic wait_out(input int n);
    int b = 0;
    while (got_q.size() < n && b < 300) begin @(negedge clk); b++; end
  endtask

  task automatic pulse_clr();
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    #23;
    checks++;
    if ({out_valid, out_corrected, out_uncorrectable} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got=%b required=000", {out_valid, out_corrected, out_uncorrectable});
    end
    checks++;
    if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h required=00", out_data); end
    checks++;
    if (single_err_cnt !== 16'h0 || double_err_cnt !== 16'h0) begin
      errors++; $display("FAIL reset_cnt got=%h/%h required=0/0", single_err_cnt, double_err_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
  endtask

  task automatic test_clean();
    @(posedge clk); #1;
    pulse_clr();
    send(8'hAA, 2'b00, 4'd0);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL clean_latency1 out_valid=%b required=0", out_valid); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hAA) begin
      errors++; $display("FAIL clean_latency2 out_valid=%b data=%h required=1/aa", out_valid, out_data);
    end
    @(posedge clk); #1;
    send(8'hCC, 2'b00, 4'd0);
    send(8'hF0, 2'b00, 4'd0);
    send(8'h01, 2'b00, 4'd0);
    wait_out(4);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL clean_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL clean[%0d] got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (single_err_cnt !== 16'd0 || double_err_cnt !== 16'd0) begin
      errors++; $display("FAIL clean_cnt got=%0d/%0d required=0/0", single_err_cnt, double_err_cnt);
    end
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    pulse_clr();
    for (int p = 0; p < CODE_W; p++) send(8'hCC, 2'b01, 4'(p));
    wait_out(CODE_W);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL single_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL single[pos %0d] got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (single_err_cnt !== 16'd13 || double_err_cnt !== 16'd0) begin
      errors++; $display("FAIL single_cnt got=%0d/%0d required=13/0", single_err_cnt, double_err_cnt);
    end
    checks++;
    if (single_err_cnt_s !== 2'd3) begin errors++; $display("FAIL single_sat got=%0d required=3", single_err_cnt_s); end
  endtask

  task automatic test_double();
    @(posedge clk); #1;
    pulse_clr();
    send(8'h55, 2'b10, 4'd3);
    send(8'h55, 2'b10, 4'd12);
    wait_out(2);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL double_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL double[%0d] got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (double_err_cnt !== 16'd2 || single_err_cnt !== 16'd0) begin
      errors++; $display("FAIL double_cnt got=%0d/%0d required=0/2", single_err_cnt, double_err_cnt);
    end
  endtask

  task automatic test_back_pressure();
    int bad = 0;
    @(posedge clk); #1;
    pulse_clr();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(8'(8'h10 + i), 2'b00, 4'd0);
      end
    join_none
    repeat (5) begin
      @(negedge clk);
      if (out_valid && out_data !== 8'h10) bad++;
    end
    checks++;
    if (in_ready !== 1'b0 || exp_q.size() != 2) begin
      errors++; $display("FAIL bp_stall in_ready=%b accepted=%0d required=0/2", in_ready, exp_q.size());
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h10 || bad != 0) begin
      errors++; $display("FAIL bp_hold out_valid=%b data=%h unstable=%0d required=1/10/0", out_valid, out_data, bad);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_out(5);
    checks++;
    if (got_q.size() != 5 || exp_q.size() != 5) begin
      errors++; $display("FAIL bp_count got=%0d sent=%0d required=5", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp[%0d] got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_counters();
    int b = 0;
    @(posedge clk); #1;
    pulse_clr();
    for (int i = 0; i < 5; i++) send(8'($urandom), 2'b01, 4'($urandom_range(0, CODE_W - 1)));
    wait_out(5);
    foreach (exp_q[i]) begin
      checks++;
      if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL cnt_data[%0d] got=%h required=%h", i, got_q[i], exp_q[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (single_err_cnt_s !== 2'd3 || single_err_cnt !== 16'd5) begin
      errors++; $display("FAIL cnt_saturate got=%0d/%0d required=3/5", single_err_cnt_s, single_err_cnt);
    end
    send(8'h5A, 2'b01, 4'd2);
    @(negedge clk);
    while (!out_valid && b < 20) begin @(negedge clk); b++; end
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL cnt_clr_wait out_valid=%b required=1", out_valid); end
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    checks++;
    if (single_err_cnt !== 16'd0 || single_err_cnt_s !== 2'd0) begin
      errors++; $display("FAIL cnt_clr_wins got=%0d/%0d required=0/0", single_err_cnt, single_err_cnt_s);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_random();
    bit done = 1'b0;
    int ns = 0;
    int nd = 0;
    @(posedge clk); #1;
    pulse_clr();
    fork
      begin
        for (int i = 0; i < 60; i++)
          send(8'($urandom), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_out(60);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL rand_count got=%0d required=%0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      checks++;
      if (got_q.size() <= i || got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL rand[%0d] got=%h required=%h", i, got_q[i], exp_q[i]);
      end
      ns += int'(exp_q[i][1]);
      nd += int'(exp_q[i][0]);
    end
    @(posedge clk); #1;
    checks++;
    if (single_err_cnt !== 16'(ns) || double_err_cnt !== 16'(nd)) begin
      errors++; $display("FAIL rand_cnt got=%0d/%0d required=%0d/%0d", single_err_cnt, double_err_cnt, ns, nd);
    end
    checks++;
    if (single_err_cnt_s !== 2'((ns > 3) ? 3 : ns) || double_err_cnt_s !== 2'((nd > 3) ? 3 : nd)) begin
      errors++; $display("FAIL rand_sat got=%0d/%0d from %0d/%0d", single_err_cnt_s, double_err_cnt_s, ns, nd);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    got_q.delete();
    exp_q.delete();
    send(8'h11, 2'b01, 4'd1);
    send(8'h22, 2'b01, 4'd2);
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rmid_inflight out_valid=%b required=1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || single_err_cnt !== 16'd0 || double_err_cnt !== 16'd0) begin
      errors++; $display("FAIL rmid_clear out_valid=%b cnt=%0d/%0d required=0/0/0", out_valid, single_err_cnt, double_err_cnt);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rmid_release in_ready=%b out_valid=%b required=1/0", in_ready, out_valid);
    end
    got_q.delete();
    exp_q.delete();
    @(posedge clk); #1;
    send(8'h3C, 2'b00, 4'd0);
    wait_out(1);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== {8'h3C, 2'b00}) begin
      errors++; $display("FAIL rmid_next got=%h count=%0d required=%h", got_q[0], got_q.size(), {8'h3C, 2'b00});
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; inject_mode = 2'b00; inject_pos = 4'd0;
    out_ready = 1'b1; clr_cnt = 1'b0;
    test_reset();
    test_clean();
    test_single();
    test_double();
    test_back_pressure();
    test_counters();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
